// File: rtl/fetch_stage_pkg.sv
// rtl/fetch_stage_pkg.sv - shared types and defaults for the instruction fetch stage
package fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT        = 32'h0000_2000;
    localparam logic [31:0] NOP_INST_DEFAULT        = 32'h0000_0013;
    localparam int          MAX_OUTSTANDING_DEFAULT = 2;

    // Fetch-to-decode register contents
    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
    } dec_entry_t;

    // Response queue entry: instruction word plus the address it was fetched from
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } q_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small parameterised FIFO with push, pop, flush and occupancy count
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int DEPTH = MAX_OUTSTANDING_DEFAULT,
    parameter int WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A push into a full queue is accepted only when the head leaves in the same cycle
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with in-flight tracking, response queue and decode register
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INST        = NOP_INST_DEFAULT,
    parameter int          MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        dec_stall,
    output logic        dec_valid,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int OW = CW + 1;

    logic          reset_done;
    logic [31:0]   pc;
    logic [CW-1:0] drop;
    dec_entry_t    dec_q;

    logic          req_fire;
    logic          dec_adv;
    logic          resp_live;
    logic          bypass;
    logic [OW-1:0] occupancy;

    // In-flight request PCs; its occupancy is the in-flight count
    logic [31:0]   pcf_head;
    logic [CW-1:0] inflight;
    logic          pcf_full;
    logic          pcf_empty;

    // Buffered responses awaiting decode
    q_entry_t      q_in;
    q_entry_t      q_head;
    logic          q_push;
    logic          q_pop;
    logic [CW-1:0] q_count;
    logic          q_full;
    logic          q_empty;

    assign occupancy      = OW'(inflight) + OW'(q_count);
    assign imem_req_valid = reset_done && (occupancy < OW'(MAX_OUTSTANDING)) && !redirect_valid;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign dec_adv   = !dec_stall || !dec_q.valid;
    // Responses to requests issued before a redirect are stale, as is any response in the redirect cycle
    assign resp_live = imem_resp_valid && (drop == '0) && !redirect_valid;
    assign bypass    = resp_live && q_empty && dec_adv;
    assign q_push    = resp_live && !bypass;
    assign q_pop     = dec_adv && !q_empty && !redirect_valid;
    assign q_in      = '{inst: imem_resp_data, pc: pcf_head};

    fetch_queue #(
        .DEPTH(MAX_OUTSTANDING),
        .WIDTH(32)
    ) u_pc_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (req_fire),
        .push_data(pc),
        .pop      (imem_resp_valid),
        .pop_data (pcf_head),
        .flush    (1'b0),
        .count    (inflight),
        .full     (pcf_full),
        .empty    (pcf_empty)
    );

    fetch_queue #(
        .DEPTH(MAX_OUTSTANDING),
        .WIDTH($bits(q_entry_t))
    ) u_resp_queue (
        .clk      (clk),
        .reset    (reset),
        .push     (q_push),
        .push_data(q_in),
        .pop      (q_pop),
        .pop_data (q_head),
        .flush    (redirect_valid),
        .count    (q_count),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reset_done <= 1'b0;
            pc         <= RESET_PC;
            drop       <= '0;
            dec_q      <= '{valid: 1'b0, inst: NOP_INST, pc: 32'h0};
        end else begin
            reset_done <= 1'b1;
            if (redirect_valid) begin
                pc          <= word_align(redirect_pc);
                // Every request still outstanding after this edge belongs to the old path
                drop        <= inflight - CW'(imem_resp_valid);
                dec_q.valid <= 1'b0;
                dec_q.inst  <= NOP_INST;
            end else begin
                if (req_fire) pc <= pc + 32'd4;
                if (imem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
                if (dec_adv) begin
                    if (!q_empty) begin
                        dec_q <= '{valid: 1'b1, inst: q_head.inst, pc: q_head.pc};
                    end else if (bypass) begin
                        dec_q <= '{valid: 1'b1, inst: imem_resp_data, pc: pcf_head};
                    end else begin
                        dec_q.valid <= 1'b0;
                        dec_q.inst  <= NOP_INST;
                    end
                end
            end
        end
    end

    assign dec_valid = dec_q.valid;
    assign dec_inst  = dec_q.inst;
    assign dec_pc    = dec_q.pc;

    a_resp_queue_full: assert property (@(posedge clk) disable iff (!reset)
        !(imem_resp_valid && q_full));
    a_resp_unrequested: assert property (@(posedge clk) disable iff (!reset)
        !(imem_resp_valid && pcf_empty));
    a_pc_fifo_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(req_fire && pcf_full && !imem_resp_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_2000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready = 1'b0;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        dec_stall = 1'b0;
    logic        dec_valid;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC(RST_PC),
        .NOP_INST(NOP),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .dec_stall      (dec_stall),
        .dec_valid      (dec_valid),
        .dec_inst       (dec_inst),
        .dec_pc         (dec_pc)
    );

    int checks = 0;
    int failures = 0;
    int consumed = 0;
    bit mem_rand = 1'b0;
    bit mem_hold = 1'b0;
    logic [31:0] mem_q[$];
    logic [31:0] exp_req_pc;
    logic [31:0] exp_dec_pc;

    typedef struct {
        bit          ready;
        bit          stall;
        bit          rv;
        logic [31:0] addr;
        bit          dv;
        logic [31:0] dpc;
    } vec_t;
    vec_t tbl[18];

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // In-order memory: answers the oldest accepted request no earlier than the next cycle
    task automatic drive_mem();
        if (mem_q.size() > 0 && !mem_hold && (!mem_rand || $urandom_range(0, 99) < 60)) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = inst_of(mem_q[0]);
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = $urandom;
        end
    endtask

    // One clock: checks against the program-order model before the edge, memory update after it
    task automatic step();
        bit          fire;
        bit          got_resp;
        bit          redir;
        logic [31:0] addr;
        logic [31:0] tgt;
        #3;
        fire     = imem_req_valid && imem_req_ready;
        got_resp = imem_resp_valid;
        redir    = redirect_valid;
        addr     = imem_req_addr;
        tgt      = redirect_pc & 32'hFFFF_FFFC;
        if (redir) chk("no_issue_on_redirect", 32'(imem_req_valid), 32'd0);
        if (fire) begin
            chk("req_addr", addr, exp_req_pc);
            exp_req_pc = exp_req_pc + 32'd4;
        end
        if (!dec_valid) begin
            chk("nop_when_idle", dec_inst, NOP);
        end else if (!dec_stall && !redir) begin
            chk("dec_pc", dec_pc, exp_dec_pc);
            chk("dec_inst", dec_inst, inst_of(exp_dec_pc));
            exp_dec_pc = exp_dec_pc + 32'd4;
            consumed++;
        end
        if (redir) begin
            exp_req_pc = tgt;
            exp_dec_pc = tgt;
        end
        @(posedge clk);
        #1;
        if (redir) begin
            chk("kill_valid", 32'(dec_valid), 32'd0);
            chk("kill_nop", dec_inst, NOP);
        end
        if (got_resp) void'(mem_q.pop_front());
        if (fire) mem_q.push_back(addr);
        chk("outstanding_bound", 32'(mem_q.size() <= 2), 32'd1);
        drive_mem();
    endtask

    task automatic wait_dec(input string name, input logic [31:0] want);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (dec_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        chk({name, "_seen"}, 32'(seen), 32'd1);
        if (seen) chk(name, dec_pc, want);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        // {ready, stall, req_valid, req_addr, dec_valid, dec_pc} per cycle after reset release
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 32'h2000, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 32'h2000, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b1, 32'h2004, 1'b0, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 32'h2008, 1'b1, 32'h2000};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 32'h200c, 1'b1, 32'h2004};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 32'h2010, 1'b1, 32'h2008};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 32'h2014, 1'b1, 32'h2008};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 32'h2014, 1'b1, 32'h2008};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 32'h2014, 1'b1, 32'h2008};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 32'h2014, 1'b1, 32'h200c};
        tbl[10] = '{1'b1, 1'b0, 1'b1, 32'h2018, 1'b1, 32'h2010};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 32'h201c, 1'b1, 32'h2014};
        tbl[12] = '{1'b0, 1'b0, 1'b1, 32'h201c, 1'b1, 32'h2018};
        tbl[13] = '{1'b0, 1'b0, 1'b1, 32'h201c, 1'b0, 32'h2018};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 32'h201c, 1'b0, 32'h2018};
        tbl[15] = '{1'b1, 1'b0, 1'b1, 32'h201c, 1'b0, 32'h2018};
        tbl[16] = '{1'b1, 1'b0, 1'b1, 32'h2020, 1'b0, 32'h2018};
        tbl[17] = '{1'b1, 1'b0, 1'b1, 32'h2024, 1'b1, 32'h201c};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, RST_PC);
        chk("rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("rst_dec_inst", dec_inst, NOP);
        chk("rst_dec_pc", dec_pc, 32'h0);

        reset = 1'b1;
        exp_req_pc = RST_PC;
        exp_dec_pc = RST_PC;
        drive_mem();

        for (int i = 0; i < 18; i++) begin
            imem_req_ready = tbl[i].ready;
            dec_stall      = tbl[i].stall;
            #2;
            chk($sformatf("tbl%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_req_addr", i), imem_req_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_dec_valid", i), 32'(dec_valid), 32'(tbl[i].dv));
            chk($sformatf("tbl%0d_dec_pc", i), dec_pc, tbl[i].dpc);
            chk($sformatf("tbl%0d_dec_inst", i), dec_inst, tbl[i].dv ? inst_of(tbl[i].dpc) : NOP);
            step();
        end

        // Redirect with two requests in flight: both stale responses must vanish
        imem_req_ready  = 1'b1;
        dec_stall       = 1'b0;
        mem_hold        = 1'b1;
        imem_resp_valid = 1'b0;
        repeat (3) step();
        chk("two_in_flight", 32'(mem_q.size()), 32'd2);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3002;
        step();
        redirect_valid = 1'b0;
        mem_hold       = 1'b0;
        drive_mem();
        wait_dec("redir_first_pc", 32'h0000_3000);

        // Redirect coinciding with a response while decode is stalled
        for (int k = 0; k < 10 && !imem_resp_valid; k++) step();
        chk("resp_for_redirect", 32'(imem_resp_valid), 32'd1);
        dec_stall      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000;
        step();
        chk("redir_stall_dv", 32'(dec_valid), 32'd0);
        redirect_valid = 1'b0;
        dec_stall      = 1'b0;
        wait_dec("redir2_first_pc", 32'h0000_4000);

        // Fetch across the top of the address space
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        step();
        redirect_valid = 1'b0;
        repeat (8) step();

        // Asynchronous reset with the queue full
        dec_stall = 1'b1;
        repeat (6) step();
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("mid_rst_req_addr", imem_req_addr, RST_PC);
        chk("mid_rst_dec_valid", 32'(dec_valid), 32'd0);
        chk("mid_rst_dec_inst", dec_inst, NOP);
        chk("mid_rst_dec_pc", dec_pc, 32'h0);
        mem_q.delete();
        imem_resp_valid = 1'b0;
        dec_stall       = 1'b0;
        @(posedge clk);
        #1;
        reset      = 1'b1;
        exp_req_pc = RST_PC;
        exp_dec_pc = RST_PC;
        wait_dec("restart_pc", RST_PC);

        // Randomised traffic against the program-order model
        mem_rand = 1'b1;
        consumed = 0;
        for (int c = 0; c < 3000; c++) begin
            imem_req_ready = ($urandom_range(0, 99) < 75);
            dec_stall      = ($urandom_range(0, 99) < 30);
            redirect_valid = ($urandom_range(0, 99) < 3);
            redirect_pc    = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : $urandom;
            step();
        end
        redirect_valid = 1'b0;
        chk("random_progress", 32'(consumed >= 300), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
